// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Trap sequencer sitting between the MEM-stage exception flags and the CSR
// register file. In S_IDLE it picks the highest-priority event (interrupt,
// exception or mret) from a valid MEM-stage instruction, then walks a short
// fixed sequence:
//   trap : S_IDLE -> S_TRAP  -> S_REDIR -> S_IDLE
//   mret : S_IDLE -> S_MRET  -> S_REDIR -> S_IDLE
// S_TRAP / S_MRET write the CSR file, S_REDIR loads the new PC. The pipeline
// is flushed in S_TRAP / S_MRET and stalled throughout the sequence.
//
// Configuration macro:
//   TRAP_VECTORED_EN  when defined, interrupts taken with mtvec[1:0]==2'b01
//                     vector to base + 4*mcause[3:0]; exceptions always use
//                     the base. When undefined, mtvec[1:0] are ignored.
//
// Parameters:
//   RESET_PC     redirect target for a trap while mtvec reads 0
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous, active-low reset
//   valid_mem    MEM-stage instruction is valid (not a bubble)
//   pc_mem       PC of the MEM-stage instruction
//   inst_mem     MEM-stage instruction word (mtval for illegal instruction)
//   bad_addr     faulting data address (mtval for load/store faults)
//   illegal, ecall, ebreak, ld_fault, st_fault   exception flags
//   mret         mret instruction in MEM
//   ext_int      level external interrupt, synchronous to clk
//   mstatus      CSR read-back, bit 3 = MIE
//   mtvec        CSR read-back, trap vector
//   mepc_i       CSR read-back, mepc
//   is_trap      CSR write strobe for a trap (S_TRAP only)
//   is_mret      CSR write strobe for mret (S_MRET only)
//   mepc, mcause, mtval   values written into the CSR file
//   flush        kill IF/ID/EX/MEM contents
//   stall        freeze PC and pipeline registers, block CSR-instruction writes
//   redirect     load redirect_pc into the PC this cycle
//   redirect_pc  new PC
//   int_ack      one-cycle pulse when an external interrupt is taken
// -----------------------------------------------------------------------------
module trap_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_mem,
    input  logic [31:0] pc_mem,
    input  logic [31:0] inst_mem,
    input  logic [31:0] bad_addr,
    input  logic        illegal,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        ld_fault,
    input  logic        st_fault,
    input  logic        mret,
    input  logic        ext_int,
    input  logic [31:0] mstatus,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_i,
    output logic        is_trap,
    output logic        is_mret,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic        flush,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        int_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP,
        S_MRET,
        S_REDIR
    } state_t;

    localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_LD      = 32'd5;
    localparam logic [31:0] CAUSE_ST      = 32'd7;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;

    state_t      state;
    state_t      state_next;

    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic        from_mret_q;

    logic        take_int;
    logic        take_exc;
    logic        take_trap;
    logic        take_mret;
    logic [31:0] cause_sel;
    logic [31:0] tval_sel;
    logic [31:0] trap_target;
    logic [31:0] mtvec_base;

    // Only the MIE bit of mstatus matters here.
    logic        unused_mstatus;
    assign unused_mstatus = ^{mstatus[31:4], mstatus[2:0]};

    // An interrupt that is masked or arrives on a bubble is simply not taken;
    // the level stays on ext_int so it is seen again later.
    assign take_int  = valid_mem & ext_int & mstatus[3];
    assign take_exc  = valid_mem & (illegal | ebreak | ecall | ld_fault | st_fault);
    assign take_trap = take_int | take_exc;
    assign take_mret = valid_mem & mret & ~take_trap;

    // Priority encoder for cause and trap value.
    always_comb begin
        cause_sel = 32'h0;
        tval_sel  = 32'h0;
        if (take_int) begin
            cause_sel = CAUSE_EXT_INT;
            tval_sel  = 32'h0;
        end else if (illegal) begin
            cause_sel = CAUSE_ILLEGAL;
            tval_sel  = inst_mem;
        end else if (ebreak) begin
            cause_sel = CAUSE_EBREAK;
            tval_sel  = pc_mem;
        end else if (ecall) begin
            cause_sel = CAUSE_ECALL;
            tval_sel  = 32'h0;
        end else if (ld_fault) begin
            cause_sel = CAUSE_LD;
            tval_sel  = bad_addr;
        end else if (st_fault) begin
            cause_sel = CAUSE_ST;
            tval_sel  = bad_addr;
        end
    end

    // State register and the trap context held across the sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mepc_q      <= 32'h0;
            mcause_q    <= 32'h0;
            mtval_q     <= 32'h0;
            from_mret_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE) begin
                if (take_trap) begin
                    mepc_q      <= pc_mem;
                    mcause_q    <= cause_sel;
                    mtval_q     <= tval_sel;
                    from_mret_q <= 1'b0;
                end else if (take_mret) begin
                    from_mret_q <= 1'b1;
                end
            end
        end
    end

    // Next-state logic; inputs are only looked at in S_IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (take_trap) begin
                    state_next = S_TRAP;
                end else if (take_mret) begin
                    state_next = S_MRET;
                end
            end
            S_TRAP:  state_next = S_REDIR;
            S_MRET:  state_next = S_REDIR;
            S_REDIR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Trap handler address. An all-zero mtvec means no handler has been
    // installed yet, so fall back to RESET_PC.
    assign mtvec_base = {mtvec[31:2], 2'b00};

    always_comb begin
        trap_target = mtvec_base;
        if (mtvec == 32'h0) begin
            trap_target = RESET_PC;
        end
`ifdef TRAP_VECTORED_EN
        else if ((mtvec[1:0] == 2'b01) && mcause_q[31]) begin
            trap_target = mtvec_base + {26'h0, mcause_q[3:0], 2'b00};
        end
`endif
    end

    // Outputs decode from state and held registers only, so is_trap/is_mret
    // have no combinational path from the MEM-stage flags.
    always_comb begin
        is_trap     = 1'b0;
        is_mret     = 1'b0;
        mepc        = 32'h0;
        mcause      = 32'h0;
        mtval       = 32'h0;
        flush       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        int_ack     = 1'b0;
        case (state)
            S_TRAP: begin
                is_trap = 1'b1;
                flush   = 1'b1;
                stall   = 1'b1;
                mepc    = mepc_q;
                mcause  = mcause_q;
                mtval   = mtval_q;
                int_ack = mcause_q[31];
            end
            S_MRET: begin
                // Feed back the current CSR contents so the write is a no-op.
                is_mret = 1'b1;
                flush   = 1'b1;
                stall   = 1'b1;
                mepc    = mepc_i;
                mcause  = mcause_q;
                mtval   = mtval_q;
            end
            S_REDIR: begin
                redirect    = 1'b1;
                stall       = 1'b1;
                redirect_pc = from_mret_q ? {mepc_i[31:2], 2'b00} : trap_target;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//
// Self-checking bench for trap_ctrl. Each stimulus computes its expected
// CSR write / redirect from a small reference model and pushes it onto a
// scoreboard queue; a monitor on the falling clock edge pops entries as the
// DUT raises is_trap/is_mret and checks the redirect on the following cycle.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_mem;
    logic [31:0] pc_mem;
    logic [31:0] inst_mem;
    logic [31:0] bad_addr;
    logic        illegal;
    logic        ecall;
    logic        ebreak;
    logic        ld_fault;
    logic        st_fault;
    logic        mret;
    logic        ext_int;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc_i;
    logic        is_trap;
    logic        is_mret;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        int_ack;

    trap_ctrl #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_mem   (valid_mem),
        .pc_mem      (pc_mem),
        .inst_mem    (inst_mem),
        .bad_addr    (bad_addr),
        .illegal     (illegal),
        .ecall       (ecall),
        .ebreak      (ebreak),
        .ld_fault    (ld_fault),
        .st_fault    (st_fault),
        .mret        (mret),
        .ext_int     (ext_int),
        .mstatus     (mstatus),
        .mtvec       (mtvec),
        .mepc_i      (mepc_i),
        .is_trap     (is_trap),
        .is_mret     (is_mret),
        .mepc        (mepc),
        .mcause      (mcause),
        .mtval       (mtval),
        .flush       (flush),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .int_ack     (int_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kind_mret;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] rpc;
        logic        ack;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          check_count = 0;
    int          pass_count  = 0;
    logic        redir_wait  = 1'b0;
    int          redirect_seen = 0;
    logic [31:0] held_mcause = 32'h0;
    logic [31:0] held_mtval  = 32'h0;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model for a taken trap: remembers the context the DUT holds.
    task automatic makeTrap(input logic [31:0] cause, input logic [31:0] tval, output exp_t e);
        logic [31:0] base;
        e.kind_mret = 1'b0;
        e.mepc      = pc_mem;
        e.mcause    = cause;
        e.mtval     = tval;
        e.ack       = cause[31];
        base        = {mtvec[31:2], 2'b00};
        if (mtvec == 32'h0) begin
            e.rpc = RPC;
        end else begin
            e.rpc = base;
`ifdef TRAP_VECTORED_EN
            if (mtvec[1:0] == 2'b01 && cause[31]) begin
                e.rpc = base + (32'(cause[3:0]) * 32'd4);
            end
`endif
        end
        held_mcause = cause;
        held_mtval  = tval;
    endtask

    // Flags vector f = {ext_int, illegal, ebreak, ecall, ld_fault, st_fault, mret}.
    // Called on a falling edge; returns on a falling edge with the DUT idle.
    task automatic applyStimulus(input string tag, input logic v, input logic [6:0] f);
        exp_t e;
        logic expect_ev;
        expect_ev = 1'b1;
        e = '{default: '0};
        if (!v) begin
            expect_ev = 1'b0;
        end else if (f[6] && mstatus[3]) begin
            makeTrap(32'h8000_000B, 32'h0, e);
        end else if (f[5]) begin
            makeTrap(32'd2, inst_mem, e);
        end else if (f[4]) begin
            makeTrap(32'd3, pc_mem, e);
        end else if (f[3]) begin
            makeTrap(32'd11, 32'h0, e);
        end else if (f[2]) begin
            makeTrap(32'd5, bad_addr, e);
        end else if (f[1]) begin
            makeTrap(32'd7, bad_addr, e);
        end else if (f[0]) begin
            e.kind_mret = 1'b1;
            e.mepc      = mepc_i;
            e.mcause    = held_mcause;
            e.mtval     = held_mtval;
            e.rpc       = {mepc_i[31:2], 2'b00};
            e.ack       = 1'b0;
        end else begin
            expect_ev = 1'b0;
        end
        if (expect_ev) sb.push_back(e);

        valid_mem = v;
        {ext_int, illegal, ebreak, ecall, ld_fault, st_fault, mret} = f;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_event"}, 32'(is_trap | is_mret), 32'(expect_ev));
        valid_mem = 1'b0;
        {ext_int, illegal, ebreak, ecall, ld_fault, st_fault, mret} = 7'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Reset pulled while the DUT sits in S_TRAP must cancel the redirect.
    task automatic applyResetMidTrap();
        exp_t e;
        int   seen_before;
        pc_mem   = 32'h0000_0400;
        inst_mem = 32'h0000_0000;
        makeTrap(32'd2, inst_mem, e);
        sb.push_back(e);
        valid_mem = 1'b1;
        illegal   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_in_trap", 32'(is_trap), 32'd1);
        valid_mem = 1'b0;
        illegal   = 1'b0;
        seen_before = redirect_seen;
        #1 rst = 1'b0;
        held_mcause = 32'h0;
        held_mtval  = 32'h0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_redirect", 32'(redirect), 32'd0);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_redirect_count", 32'(redirect_seen), 32'(seen_before));
        checkOutput("abort_idle_stall", 32'(stall), 32'd0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            redir_wait = 1'b0;
        end else begin
            if (redir_wait) begin
                checkOutput("redirect_latency", 32'(redirect), 32'd1);
                if (redirect) begin
                    redirect_seen++;
                    checkOutput("redirect_pc", redirect_pc, cur.rpc);
                    checkOutput("redir_stall", 32'(stall), 32'd1);
                    checkOutput("redir_flush", 32'(flush), 32'd0);
                end
                redir_wait = 1'b0;
            end else if (redirect) begin
                redirect_seen++;
                checkOutput("unexpected_redirect", 32'd1, 32'd0);
            end
            if (is_trap || is_mret) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_event", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    checkOutput("is_mret", 32'(is_mret), 32'(cur.kind_mret));
                    checkOutput("is_trap", 32'(is_trap), 32'(!cur.kind_mret));
                    checkOutput("mepc", mepc, cur.mepc);
                    checkOutput("mcause", mcause, cur.mcause);
                    checkOutput("mtval", mtval, cur.mtval);
                    checkOutput("int_ack", 32'(int_ack), 32'(cur.ack));
                    checkOutput("ev_flush", 32'(flush), 32'd1);
                    checkOutput("ev_stall", 32'(stall), 32'd1);
                    redir_wait = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        valid_mem = 1'b0;
        pc_mem    = 32'h0;
        inst_mem  = 32'h0;
        bad_addr  = 32'h0;
        {ext_int, illegal, ebreak, ecall, ld_fault, st_fault, mret} = 7'b0;
        mstatus   = 32'h0;
        mtvec     = 32'h0;
        mepc_i    = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("rst_strobes", 32'({is_trap, is_mret, flush, stall, redirect, int_ack}), 32'd0);
        checkOutput("rst_mepc", mepc, 32'h0);
        checkOutput("rst_mcause", mcause, 32'h0);
        checkOutput("rst_mtval", mtval, 32'h0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Illegal instruction.
        pc_mem = 32'h100; inst_mem = 32'hFFFF_FFFF; mtvec = 32'h200;
        applyStimulus("illegal", 1'b1, 7'b0100000);

        // ecall beats ld_fault.
        pc_mem = 32'h104; bad_addr = 32'hDEAD_0000;
        applyStimulus("ecall_ld", 1'b1, 7'b0001100);

        // ebreak, load fault, store fault.
        pc_mem = 32'h108;
        applyStimulus("ebreak", 1'b1, 7'b0010000);
        bad_addr = 32'h1000_0004;
        applyStimulus("ld_fault", 1'b1, 7'b0000100);
        bad_addr = 32'h1000_0008;
        applyStimulus("st_fault", 1'b1, 7'b0000010);

        // Bubble carrying a flag is ignored.
        applyStimulus("bubble", 1'b0, 7'b0100000);

        // Masked interrupt, then unmasked.
        pc_mem = 32'h120; mstatus = 32'h80;
        applyStimulus("int_masked", 1'b1, 7'b1000000);
        mstatus = 32'h88;
        applyStimulus("int_taken", 1'b1, 7'b1000000);

        // Interrupt beats illegal.
        pc_mem = 32'h124;
        applyStimulus("int_vs_illegal", 1'b1, 7'b1100000);
        mstatus = 32'h0;

        // mret returns to mepc_i, with low bits cleared on the redirect.
        mepc_i = 32'h344;
        applyStimulus("mret", 1'b1, 7'b0000001);
        mepc_i = 32'h347;
        applyStimulus("mret_unaligned", 1'b1, 7'b0000001);

        // mret is dropped when a trap is taken alongside it.
        pc_mem = 32'h130;
        applyStimulus("mret_vs_ecall", 1'b1, 7'b0001001);

        // Unprogrammed mtvec falls back to RESET_PC.
        mtvec = 32'h0;
        applyStimulus("mtvec_zero", 1'b1, 7'b0001000);

        // Vectored-capable mtvec: interrupt vs exception.
        mtvec = 32'h301; mstatus = 32'h8; pc_mem = 32'h140;
        applyStimulus("vec_int", 1'b1, 7'b1000000);
        applyStimulus("vec_ecall", 1'b1, 7'b0001000);
        mstatus = 32'h0;

        // Reset in the middle of a sequence, then mret shows held regs cleared.
        mtvec = 32'h200;
        applyResetMidTrap();
        mepc_i = 32'h500;
        applyStimulus("mret_after_rst", 1'b1, 7'b0000001);

        // Randomised events.
        for (int i = 0; i < 24; i++) begin
            pc_mem   = $urandom & 32'hFFFF_FFFC;
            inst_mem = $urandom;
            bad_addr = $urandom;
            mstatus  = ($urandom_range(0, 1) != 0) ? 32'h8 : 32'h0;
            mtvec    = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'h0000_FFFD);
            mepc_i   = $urandom;
            applyStimulus("rand", ($urandom_range(0, 4) != 0), 7'($urandom));
        end

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
